serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 122 ++++++++++++
 tb/tb_serial_frame_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Samples sin only on bit_en strobes and reports each finished frame with a one-cycle status pulse.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              CLRN,
    input  logic              sin,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                par_q, par_d;
    logic                stop_q, stop_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;

    function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
        return ((^d) ^ ODD_PARITY) != p;
    endfunction

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        stop_d  = stop_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_en && !sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    // Right shift so the first bit received lands at bit 0.
                    shreg_d = {sin, shreg_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_en) begin
                    par_d   = sin;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_en) begin
                    stop_d  = sin;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Any strobe landing here is deliberately dropped.
                state_d = IDLE;
                data_d  = shreg_q;
                ferr_d  = !stop_q;
                perr_d  = stop_q && PARITY_EN && parity_bad(shreg_q, par_q);
                valid_d = stop_q && !(PARITY_EN && parity_bad(shreg_q, par_q));
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: parity-enabled instance driven from a vector table,
// plus hand sequences for reset abort, back-to-back frames and strobe gating without parity.
module tb_serial_frame_rx;

    logic       clk;
    logic       CLRN;
    logic       sin0, ben0, sin1, ben1;
    logic [7:0] dout0, dout1;
    logic       valid0, perr0, ferr0, busy0;
    logic       valid1, perr1, ferr1, busy1;

    int n_cmp;
    int n_err;
    int pulses0;
    int pulses1;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b0)) dut0 (
        .clk(clk), .CLRN(CLRN), .sin(sin0), .bit_en(ben0),
        .data_out(dout0), .valid(valid0), .parity_err(perr0),
        .frame_err(ferr0), .busy(busy0)
    );

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0), .ODD_PARITY(1'b0)) dut1 (
        .clk(clk), .CLRN(CLRN), .sin(sin1), .bit_en(ben1),
        .data_out(dout1), .valid(valid1), .parity_err(perr1),
        .frame_err(ferr1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid0 || perr0 || ferr0) pulses0++;
        if (valid1 || perr1 || ferr1) pulses1++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ev;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Caller sits on a negedge; strobe lasts one clk, then gap idle clks.
    task automatic send_bit(input logic b, input int gap);
        sin0 = b;
        ben0 = 1'b1;
        @(negedge clk);
        ben0 = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_body(input string name, input logic [7:0] d, input logic p, input logic s,
                             input logic ev, input logic ep, input logic ef);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1);
        send_bit(p, 1);
        send_bit(s, 0);
        chk({name, "_busy_done"}, busy0, 1);
        chk({name, "_noflag_done"}, {valid0, perr0, ferr0}, 0);
        @(negedge clk);
        chk({name, "_data"}, dout0, d);
        chk({name, "_valid"}, valid0, ev);
        chk({name, "_perr"}, perr0, ep);
        chk({name, "_ferr"}, ferr0, ef);
        chk({name, "_busy_idle"}, busy0, 0);
        sin0 = 1'b1;
    endtask

    task automatic send_bit1(input logic b, input int gap);
        sin1 = b;
        ben1 = 1'b1;
        @(negedge clk);
        ben1 = 1'b0;
        for (int i = 0; i < gap; i++) begin
            sin1 = ~sin1;
            @(negedge clk);
        end
    endtask

    initial begin
        int p_before;
        logic [7:0] d1;
        n_cmp = 0;
        n_err = 0;
        pulses0 = 0;
        pulses1 = 0;
        sin0 = 1'b1; ben0 = 1'b0;
        sin1 = 1'b1; ben1 = 1'b0;
        CLRN = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        #3;
        chk("rst_data0", dout0, 0);
        chk("rst_flags0", {valid0, perr0, ferr0, busy0}, 0);
        chk("rst_data1", dout1, 0);
        chk("rst_flags1", {valid1, perr1, ferr1, busy1}, 0);
        @(negedge clk);
        CLRN = 1'b1;
        repeat (2) @(negedge clk);

        chk("idle_busy", busy0, 0);
        for (int v = 0; v < 8; v++) begin
            send_bit(1'b0, 1);
            chk($sformatf("vec%0d_busy_start", v), busy0, 1);
            send_body($sformatf("vec%0d", v), vecs[v].data, vecs[v].par, vecs[v].stop,
                      vecs[v].ev, vecs[v].ep, vecs[v].ef);
            repeat (2) @(negedge clk);
        end

        // Abort a frame after three data bits with an asynchronous clear.
        p_before = pulses0;
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        #2 CLRN = 1'b0;
        #1;
        chk("abort_busy_async", busy0, 0);
        chk("abort_data_async", dout0, 0);
        @(negedge clk);
        CLRN = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_pulse", pulses0 - p_before, 0);
        chk("abort_busy", busy0, 0);
        send_bit(1'b0, 1);
        send_body("after_abort", 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Back-to-back: next start strobe on the first legal cycle after DONE.
        send_bit(1'b0, 1);
        send_body("b2b_first", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 0);
        chk("b2b_busy_restart", busy0, 1);
        @(negedge clk);
        send_body("b2b_second", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_pulse_width", {valid0, perr0, ferr0}, 0);

        // No-parity instance with sparse strobes and a noisy line between them.
        d1 = 8'h5A;
        p_before = pulses1;
        send_bit1(1'b0, 5);
        for (int i = 0; i < 8; i++) send_bit1(d1[i], 5);
        chk("np_busy_after9", busy1, 1);
        chk("np_no_pulse_after9", pulses1 - p_before, 0);
        send_bit1(1'b1, 0);
        chk("np_busy_done", busy1, 1);
        chk("np_noflag_done", {valid1, perr1, ferr1}, 0);
        @(negedge clk);
        chk("np_data", dout1, 8'h5A);
        chk("np_valid", valid1, 1);
        chk("np_perr", perr1, 0);
        chk("np_ferr", ferr1, 0);
        chk("np_busy_idle", busy1, 0);
        sin1 = 1'b1;
        @(negedge clk);
        chk("np_one_pulse", pulses1 - p_before, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
